// File: rtl/instr_fetch_pkg.sv
// Shared types and configuration for the veriRISCV instruction-fetch stage:
// IF/ID pipeline register layout, fetch FSM states and the default reset PC.
package instr_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT
    } fetch_state_e;

    typedef struct packed {
        logic valid;
    } if2id_pipeline_ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } if2id_pipeline_data_t;

    // Sequential fetch advances one 32-bit word; the sum wraps modulo 2^32.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched instruction that arrived while
// decode was stalled. Clear wins over load.
module fetch_skid_buffer
    import instr_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;

    // NOTE: a single entry is cheap, so its data is reset too; that keeps
    // the outputs free of X even though only valid_q needs a defined value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding reads on the
// instruction bus and fills the IF/ID register, handling stall, flush and redirects.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_stall,
    input  logic                 if_flush,
    input  logic                 branch_take,
    input  logic [XLEN-1:0]      branch_pc,
    input  logic                 trap_take,
    input  logic [XLEN-1:0]      trap_pc,
    output logic                 ibus_read,
    output logic [XLEN-1:0]      ibus_address,
    input  logic                 ibus_waitrequest,
    input  logic                 ibus_readdatavalid,
    input  logic [XLEN-1:0]      ibus_readdata,
    output if2id_pipeline_ctrl_t if2id_pipeline_ctrl,
    output if2id_pipeline_data_t if2id_pipeline_data
);

    fetch_state_e         state_q, state_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [XLEN-1:0]      req_pc_q, req_pc_d;
    logic                 drop_q, drop_d;
    if2id_pipeline_ctrl_t ctrl_q, ctrl_d;
    if2id_pipeline_data_t data_q, data_d;

    logic            in_idle, in_req, in_wait;
    logic            redirect, resp, live, issue, accept;
    logic [XLEN-1:0] redirect_pc;
    logic            buf_valid, buf_load, buf_clear;
    logic [XLEN-1:0] buf_pc, buf_instr;

    // Issue is combinational so a new request can leave in the same cycle the
    // previous response lands; gating with rst keeps the bus quiet in reset.
    always_comb begin
        in_idle     = (state_q == FETCH_IDLE);
        in_req      = (state_q == FETCH_REQ);
        in_wait     = (state_q == FETCH_WAIT);
        redirect    = trap_take | branch_take;
        redirect_pc = trap_take ? trap_pc : branch_pc;
        resp        = in_wait & ibus_readdatavalid;
        live        = resp & ~drop_q & ~redirect;
        issue       = ~rst & ~buf_valid & ~redirect
                    & (in_idle | (resp & (drop_q | ~if_stall)));
        accept      = (in_req | issue) & ~ibus_waitrequest;
        buf_load    = live & if_stall;
        buf_clear   = redirect | (~if_stall & ~if_flush);
    end

    // NOTE: every next-state signal gets its hold value first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        ctrl_d   = ctrl_q;
        data_d   = data_q;

        case (state_q)
            FETCH_IDLE: if (issue)  state_d = accept ? FETCH_WAIT : FETCH_REQ;
            FETCH_REQ:  if (accept) state_d = FETCH_WAIT;
            FETCH_WAIT: if (resp)   state_d = issue ? (accept ? FETCH_WAIT : FETCH_REQ)
                                                    : FETCH_IDLE;
            default:                state_d = FETCH_IDLE;
        endcase

        if (issue) req_pc_d = pc_q;

        // A request redirected while still in REQ is stale; its acceptance must
        // not advance the already-retargeted PC.
        if (redirect)                         pc_d = redirect_pc;
        else if (accept & ~(in_req & drop_q)) pc_d = next_pc(pc_q);

        if (redirect)  drop_d = in_req | (in_wait & ~ibus_readdatavalid);
        else if (resp) drop_d = 1'b0;

        if (redirect || if_flush) begin
            ctrl_d.valid = 1'b0;
        end else if (!if_stall) begin
            if (buf_valid) begin
                ctrl_d.valid       = 1'b1;
                data_d.pc          = buf_pc;
                data_d.instruction = buf_instr;
            end else if (live) begin
                ctrl_d.valid       = 1'b1;
                data_d.pc          = req_pc_q;
                data_d.instruction = ibus_readdata;
            end else begin
                ctrl_d.valid       = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            drop_q   <= 1'b0;
            ctrl_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            ctrl_q   <= ctrl_d;
            data_q   <= data_d;
        end
    end

    fetch_skid_buffer u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .pc_i    (req_pc_q),
        .instr_i (ibus_readdata),
        .valid_o (buf_valid),
        .pc_o    (buf_pc),
        .instr_o (buf_instr)
    );

    assign ibus_read           = in_req | issue;
    assign ibus_address        = in_req ? req_pc_q : pc_q;
    assign if2id_pipeline_ctrl = ctrl_q;
    assign if2id_pipeline_data = data_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run,
// checked against a program-order instruction-stream model and a bus memory model.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 if_stall = 1'b0;
    logic                 if_flush = 1'b0;
    logic                 branch_take = 1'b0;
    logic [31:0]          branch_pc = '0;
    logic                 trap_take = 1'b0;
    logic [31:0]          trap_pc = '0;
    logic                 ibus_read;
    logic [31:0]          ibus_address;
    logic                 ibus_waitrequest = 1'b0;
    logic                 ibus_readdatavalid = 1'b0;
    logic [31:0]          ibus_readdata = '0;
    if2id_pipeline_ctrl_t if2id_ctrl;
    if2id_pipeline_data_t if2id_data;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .if_stall            (if_stall),
        .if_flush            (if_flush),
        .branch_take         (branch_take),
        .branch_pc           (branch_pc),
        .trap_take           (trap_take),
        .trap_pc             (trap_pc),
        .ibus_read           (ibus_read),
        .ibus_address        (ibus_address),
        .ibus_waitrequest    (ibus_waitrequest),
        .ibus_readdatavalid  (ibus_readdatavalid),
        .ibus_readdata       (ibus_readdata),
        .if2id_pipeline_ctrl (if2id_ctrl),
        .if2id_pipeline_data (if2id_data)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: memory with a single outstanding request, and the
    // next program-order PC decode expects to consume.
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          cnt = 0;
    int          lat = 1;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_addr = '0;
    logic [31:0] exp_pc = '0;
    int          consumed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        if_stall = 1'b0; if_flush = 1'b0; branch_take = 1'b0; trap_take = 1'b0;
        ibus_waitrequest = 1'b0; ibus_readdatavalid = 1'b0;
        #1;
        check("rst_read", ibus_read, 0);
        check("rst_addr", ibus_address, 32'h0);
        check("rst_valid", if2id_ctrl.valid, 0);
        check("rst_pc", if2id_data.pc, 32'h0);
        check("rst_instr", if2id_data.instruction, 32'h0);
        @(negedge clk);
        pend = 1'b0; hold_prev = 1'b0; exp_pc = 32'h0;
    endtask

    // One clock cycle: drive inputs at the falling edge, let combinational
    // outputs settle, check them, then advance the memory and stream models.
    task automatic cycle(input logic st, input logic fl, input logic bt, input logic [31:0] bpc,
                         input logic tt, input logic [31:0] tpc, input logic wr);
        @(negedge clk);
        rst = 1'b0;
        if_stall = st; if_flush = fl;
        branch_take = bt; branch_pc = bpc;
        trap_take = tt; trap_pc = tpc;
        ibus_waitrequest = wr;
        if (pend && cnt == 0) begin
            ibus_readdatavalid = 1'b1;
            ibus_readdata = mem_word(pend_addr);
        end else begin
            ibus_readdatavalid = 1'b0;
            ibus_readdata = $urandom;
        end
        #1;
        check("one_outstanding", ibus_read & pend & ~ibus_readdatavalid, 0);
        if (hold_prev) begin
            check("hold_read", ibus_read, 1);
            check("hold_addr", ibus_address, hold_addr);
        end
        if (ibus_read) check("aligned", ibus_address[1:0], 0);

        if (tt || bt) begin
            exp_pc = tt ? tpc : bpc;
        end else if (!fl && !st && if2id_ctrl.valid) begin
            check("stream_pc", if2id_data.pc, exp_pc);
            check("stream_instr", if2id_data.instruction, mem_word(exp_pc));
            exp_pc += 32'd4;
            consumed++;
        end

        if (pend && cnt == 0) pend = 1'b0;
        else if (pend) cnt--;
        if (ibus_read && !wr) begin
            pend = 1'b1;
            pend_addr = ibus_address;
            cnt = lat - 1;
        end
        hold_prev = ibus_read & wr;
        hold_addr = ibus_address;
    endtask

    initial begin
        // Back-to-back fetch with an ideal memory.
        lat = 1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            check("t1_read", ibus_read, 1);
            check("t1_addr", ibus_address, 32'(4 * c));
            check("t1_valid", if2id_ctrl.valid, c >= 2);
            if (c >= 2) check("t1_pc", if2id_data.pc, 32'(4 * (c - 2)));
        end

        // Waitrequest held for three cycles on 0x8.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            cycle(0, 0, 0, 0, 0, 0, (c >= 2 && c <= 4));
            if (c >= 2 && c <= 5) begin
                check("t2_read", ibus_read, 1);
                check("t2_addr", ibus_address, 32'h8);
            end
            if (c == 6) check("t2_next_addr", ibus_address, 32'hC);
            if (c == 7) check("t2_pc", if2id_data.pc, 32'h8);
        end

        // Two-cycle stall while the 0xC response arrives.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cycle((c == 4 || c == 5), 0, 0, 0, 0, 0, 0);
            if (c == 5 || c == 6) begin
                check("t3_hold_valid", if2id_ctrl.valid, 1);
                check("t3_hold_pc", if2id_data.pc, 32'h8);
                check("t3_no_fetch", ibus_read, 0);
            end
            if (c == 7) begin
                check("t3_pc", if2id_data.pc, 32'hC);
                check("t3_addr", ibus_address, 32'h10);
            end
        end

        // Branch while the 0x10 response is still in flight.
        lat = 2;
        do_reset();
        for (int c = 0; c < 15; c++) begin
            cycle(0, 0, (c == 9), 32'h100, 0, 0, 0);
            if (c == 10) check("t4_addr", ibus_address, 32'h100);
            if (c == 11) check("t4_dropped", if2id_ctrl.valid, 0);
            if (c == 13) begin
                check("t4_valid", if2id_ctrl.valid, 1);
                check("t4_pc", if2id_data.pc, 32'h100);
            end
        end

        // Trap and branch in the same cycle.
        lat = 1;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            cycle(0, 0, (c == 3), 32'h200, (c == 3), 32'h80, 0);
            if (c == 4) check("t5_addr", ibus_address, 32'h80);
            if (c == 6) check("t5_pc", if2id_data.pc, 32'h80);
        end

        // Flush together with stall, then resync with a branch.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            cycle((c == 3), (c == 3), (c == 4), 32'h40, 0, 0, 0);
            if (c == 4) check("t6_flush_valid", if2id_ctrl.valid, 0);
            if (c == 5) check("t6_addr", ibus_address, 32'h40);
            if (c == 7) check("t6_pc", if2id_data.pc, 32'h40);
        end

        // Reset pulse while a response is pending.
        lat = 2;
        do_reset();
        for (int c = 0; c < 6; c++) cycle(0, 0, 0, 0, 0, 0, 0);
        check("t7_pre_valid", if2id_ctrl.valid, 1);
        check("t7_pre_pc", if2id_data.pc, 32'h4);
        rst = 1'b1;
        #1;
        check("t7_read", ibus_read, 0);
        check("t7_valid", if2id_ctrl.valid, 0);
        check("t7_data_pc", if2id_data.pc, 32'h0);
        lat = 1;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            if (c == 0) check("t7_refetch", ibus_address, 32'h0);
            if (c == 2) check("t7_pc", if2id_data.pc, 32'h0);
        end

        // Randomized traffic against the stream and bus models.
        do_reset();
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            logic st, bt, tt, fl, wr;
            logic [31:0] bpc, tpc;
            lat = $urandom_range(1, 3);
            st  = ($urandom_range(0, 3) == 0);
            bt  = ($urandom_range(0, 99) < 4);
            tt  = ($urandom_range(0, 99) < 2);
            fl  = (bt | tt) & $urandom_range(0, 1) == 1;
            wr  = ($urandom_range(0, 9) < 3);
            bpc = 32'($urandom_range(0, 1023)) << 2;
            tpc = 32'($urandom_range(0, 1023)) << 2;
            cycle(st, fl, bt, bpc, tt, tpc, wr);
        end
        check("progress", consumed > 300, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
